// File: rtl/julia_pkg.sv
// Shared types and default geometry for the Julia renderer: dispatcher FSM states,
// default coordinate width and frame size, and a ring-index helper for the arbiters.
package julia_pkg;

    localparam int unsigned DEF_COORD_W = 10;
    localparam int unsigned DEF_IMG_W   = 640;
    localparam int unsigned DEF_IMG_H   = 480;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDrain,
        StDone
    } disp_state_e;

    // Index preceding idx on a ring of n slots.
    function automatic int unsigned prev_idx(int unsigned idx, int unsigned n);
        return (idx + n - 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the highest priority goes to last+1 and
// rotates upward. No grant is produced unless advance is high.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned WID = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic           advance,
    input  logic [WID-1:0] last,
    output logic [N-1:0]   gnt,
    output logic [WID-1:0] gnt_idx,
    output logic           any
);

    logic [WID-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = WID'((32'(last) + i) % N);
            if (advance && !any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/julia_dispatcher.sv
// Frame scheduler for a bank of Julia workers. It issues raster-order pixel jobs to idle
// workers and funnels their finished results onto the single memory write port.
module julia_dispatcher
    import julia_pkg::*;
#(
    parameter int unsigned NUM_WORKERS = 4,
    parameter int unsigned IMG_W       = DEF_IMG_W,
    parameter int unsigned IMG_H       = DEF_IMG_H,
    parameter int unsigned COORD_W     = DEF_COORD_W,
    localparam int unsigned WID        = $clog2(NUM_WORKERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    output logic                   busy,
    output logic                   frame_done,
    input  logic [NUM_WORKERS-1:0] jw_ready,
    output logic [NUM_WORKERS-1:0] jw_start,
    output logic [COORD_W-1:0]     job_x,
    output logic [COORD_W-1:0]     job_y,
    input  logic [NUM_WORKERS-1:0] jw_done,
    output logic [NUM_WORKERS-1:0] jw_mc_done,
    output logic                   mc_wr_valid,
    output logic [WID-1:0]         mc_wr_sel,
    output logic [COORD_W-1:0]     mc_wr_x,
    output logic [COORD_W-1:0]     mc_wr_y,
    input  logic                   mc_wr_ack
);

    disp_state_e            state_q, state_d;
    logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
    logic [NUM_WORKERS-1:0] busy_q, busy_d;
    // Pointers hold the index that gets first priority on the next arbitration.
    logic [WID-1:0]         iss_ptr_q, iss_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NUM_WORKERS-1:0] wgnt_oh_q, wgnt_oh_d;
    logic [WID-1:0]         wgnt_idx_q, wgnt_idx_d;
    logic [COORD_W-1:0]     cx_q [NUM_WORKERS];
    logic [COORD_W-1:0]     cy_q [NUM_WORKERS];

    logic [NUM_WORKERS-1:0] iss_req, iss_gnt, wr_req, wr_gnt, wr_ack_vec;
    logic [WID-1:0]         iss_idx, wr_idx, iss_last, wr_last;
    logic                   iss_any, wr_any, iss_en, wr_en, wr_ack, last_pix, x_wrap;

    assign iss_req  = jw_ready & ~busy_q;
    assign iss_en   = (state_q == StDispatch);
    assign iss_last = WID'(prev_idx(32'(iss_ptr_q), NUM_WORKERS));

    assign wr_req   = jw_done & busy_q;
    assign wr_en    = (state_q != StIdle) && (wgnt_oh_q == '0);
    assign wr_last  = WID'(prev_idx(32'(wr_ptr_q), NUM_WORKERS));

    rr_arbiter #(
        .N   (NUM_WORKERS),
        .WID (WID)
    ) u_iss_arb (
        .req     (iss_req),
        .advance (iss_en),
        .last    (iss_last),
        .gnt     (iss_gnt),
        .gnt_idx (iss_idx),
        .any     (iss_any)
    );

    rr_arbiter #(
        .N   (NUM_WORKERS),
        .WID (WID)
    ) u_wr_arb (
        .req     (wr_req),
        .advance (wr_en),
        .last    (wr_last),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx),
        .any     (wr_any)
    );

    assign x_wrap     = (x_q == COORD_W'(IMG_W - 1));
    assign last_pix   = x_wrap && (y_q == COORD_W'(IMG_H - 1));
    assign wr_ack     = (wgnt_oh_q != '0) && mc_wr_ack;
    assign wr_ack_vec = mc_wr_ack ? wgnt_oh_q : '0;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = (busy_q | iss_gnt) & ~wr_ack_vec;
        iss_ptr_d  = iss_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        wgnt_oh_d  = wgnt_oh_q;
        wgnt_idx_d = wgnt_idx_q;

        case (state_q)
            StIdle:     if (frame_start) state_d = StDispatch;
            StDispatch: if (iss_any && last_pix) state_d = StDrain;
            StDrain:    if (busy_q == '0) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        if (state_q == StIdle && frame_start) begin
            x_d = '0;
            y_d = '0;
        end else if (iss_any) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = last_pix ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end

        if (iss_any) iss_ptr_d = WID'((32'(iss_idx) + 1) % NUM_WORKERS);

        // Grant is released on ack and re-evaluated only in the following cycle.
        if (wr_ack) begin
            wgnt_oh_d = '0;
            wr_ptr_d  = WID'((32'(wgnt_idx_q) + 1) % NUM_WORKERS);
        end else if (wr_any) begin
            wgnt_oh_d  = wr_gnt;
            wgnt_idx_d = wr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= '0;
            iss_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            wgnt_oh_q  <= '0;
            wgnt_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            iss_ptr_q  <= iss_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            wgnt_oh_q  <= wgnt_oh_d;
            wgnt_idx_q <= wgnt_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORKERS; i++) begin
                cx_q[i] <= '0;
                cy_q[i] <= '0;
            end
        end else if (iss_any) begin
            cx_q[iss_idx] <= x_q;
            cy_q[iss_idx] <= y_q;
        end
    end

    assign busy        = (state_q != StIdle);
    assign frame_done  = (state_q == StDone);
    assign jw_start    = iss_gnt;
    assign job_x       = iss_any ? x_q : '0;
    assign job_y       = iss_any ? y_q : '0;
    assign mc_wr_valid = (wgnt_oh_q != '0);
    assign mc_wr_sel   = mc_wr_valid ? wgnt_idx_q : '0;
    assign mc_wr_x     = mc_wr_valid ? cx_q[wgnt_idx_q] : '0;
    assign mc_wr_y     = mc_wr_valid ? cy_q[wgnt_idx_q] : '0;
    assign jw_mc_done  = wr_ack_vec;

endmodule

// File: tb/tb_julia_dispatcher.sv
// Bench for julia_dispatcher on a 4x2 image with four modelled workers and a memory
// controller; issued jobs are queued and matched against the write port.
module tb_julia_dispatcher;

    localparam int NW   = 4;
    localparam int IW   = 4;
    localparam int IH   = 2;
    localparam int CW   = 10;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          rst, frame_start, busy, frame_done, mc_wr_valid, mc_wr_ack;
    logic [NW-1:0] jw_ready, jw_start, jw_done, jw_mc_done;
    logic [CW-1:0] job_x, job_y, mc_wr_x, mc_wr_y;
    logic [1:0]    mc_wr_sel;

    always #5 clk = ~clk;

    julia_dispatcher #(
        .NUM_WORKERS (NW),
        .IMG_W       (IW),
        .IMG_H       (IH),
        .COORD_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .jw_ready    (jw_ready),
        .jw_start    (jw_start),
        .job_x       (job_x),
        .job_y       (job_y),
        .jw_done     (jw_done),
        .jw_mc_done  (jw_mc_done),
        .mc_wr_valid (mc_wr_valid),
        .mc_wr_sel   (mc_wr_sel),
        .mc_wr_x     (mc_wr_x),
        .mc_wr_y     (mc_wr_y),
        .mc_wr_ack   (mc_wr_ack)
    );

    typedef struct {
        int w;
        int x;
        int y;
    } job_t;

    job_t          sb[$];
    int            iss_w[$], iss_c[$], wr_log[$];
    int            n_cmp = 0, n_bad = 0;
    int            wstate[NW], wcnt[NW], lat[NW];
    logic [NW-1:0] en;
    bit            sticky, spur, fs_req, rst_req;
    int            ack_dly, bx, by, issued, writes, fd_cnt, ack_cnt, cyc, overlap;
    bit            prev_valid, prev_ack;
    int            prev_sel;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_reset();
        bx = 0; by = 0; issued = 0; writes = 0; fd_cnt = 0;
        iss_w.delete(); iss_c.delete(); wr_log.delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            wstate[i] = 0;
            wcnt[i]   = 0;
        end
        sb.delete();
        prev_valid = 0; prev_ack = 0; prev_sel = 0; ack_cnt = 0;
        frame_reset();
    endtask

    // Everything the DUT does at the coming posedge, as seen #1 after the negedge drive.
    task automatic observe();
        bit did_iss, did_ack;
        int w, sel, idx;
        did_iss = (jw_start != '0);
        did_ack = mc_wr_valid && mc_wr_ack;
        w = -1;

        if (prev_ack) check_eq("wr_gap", int'(mc_wr_valid), 0);
        else if (prev_valid) begin
            check_eq("wr_hold_valid", int'(mc_wr_valid), 1);
            check_eq("wr_hold_sel", int'(mc_wr_sel), prev_sel);
        end
        check_eq("mc_done", int'(jw_mc_done), did_ack ? (1 << mc_wr_sel) : 0);

        for (int i = 0; i < NW; i++)
            if (wstate[i] == 1) begin
                wcnt[i]--;
                if (wcnt[i] <= 0) wstate[i] = 2;
            end

        if (did_iss) begin
            check_eq("start_onehot", int'($onehot(jw_start)), 1);
            for (int i = NW - 1; i >= 0; i--) if (jw_start[i]) w = i;
            check_eq("start_idle_worker", wstate[w], 0);
            check_eq("start_ready", int'(jw_ready[w]), 1);
            check_eq("job_x", int'(job_x), bx);
            check_eq("job_y", int'(job_y), by);
            check_eq("issue_in_frame", int'(issued < NPIX), 1);
            sb.push_back(job_t'{w, bx, by});
            iss_w.push_back(w);
            iss_c.push_back(cyc);
            issued++;
            bx++;
            if (bx == IW) begin
                bx = 0;
                by++;
            end
            wstate[w] = 1;
            wcnt[w]   = lat[w];
        end

        if (did_ack) begin
            sel = int'(mc_wr_sel);
            check_eq("wr_from_done", wstate[sel], 2);
            idx = -1;
            foreach (sb[k]) if (idx < 0 && sb[k].w == sel) idx = k;
            check_eq("wr_known_job", int'(idx >= 0), 1);
            if (idx >= 0) begin
                check_eq("wr_x", int'(mc_wr_x), sb[idx].x);
                check_eq("wr_y", int'(mc_wr_y), sb[idx].y);
                sb.delete(idx);
            end
            wr_log.push_back(sel);
            writes++;
            wstate[sel] = 0;
            ack_cnt = 0;
            if (did_iss && w != sel) overlap++;
        end else if (mc_wr_valid) begin
            ack_cnt++;
        end

        if (frame_done) begin
            fd_cnt++;
            check_eq("fd_all_issued", issued, NPIX);
            check_eq("fd_all_written", writes, NPIX);
            check_eq("fd_sb_empty", sb.size(), 0);
        end

        prev_valid = mc_wr_valid;
        prev_ack   = did_ack;
        prev_sel   = int'(mc_wr_sel);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        rst         = rst_req;
        frame_start = fs_req;
        for (int i = 0; i < NW; i++) begin
            jw_ready[i] = en[i] && (sticky || wstate[i] == 0);
            jw_done[i]  = (wstate[i] == 2);
        end
        mc_wr_ack = spur || (mc_wr_valid && ack_cnt >= ack_dly);
        #1;
        if (!rst_req) observe();
    endtask

    task automatic check_idle();
        check_eq("idle_busy", int'(busy), 0);
        check_eq("idle_jw_start", int'(jw_start), 0);
        check_eq("idle_job_x", int'(job_x), 0);
        check_eq("idle_job_y", int'(job_y), 0);
        check_eq("idle_mc_wr_valid", int'(mc_wr_valid), 0);
        check_eq("idle_mc_wr_sel", int'(mc_wr_sel), 0);
        check_eq("idle_frame_done", int'(frame_done), 0);
        check_eq("idle_jw_mc_done", int'(jw_mc_done), 0);
    endtask

    task automatic reset_dut();
        model_reset();
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        step();
        check_idle();
    endtask

    task automatic run_frame(input bit fs_in_drain);
        int  budget;
        bit  drain_pulsed;
        frame_reset();
        fs_req = 1;
        step();
        fs_req = 0;
        step();
        check_eq("first_issue_lat", issued, 1);
        check_eq("busy_in_frame", int'(busy), 1);
        budget = 0;
        drain_pulsed = 0;
        while (fd_cnt == 0 && budget < 2000) begin
            if (fs_in_drain && !drain_pulsed && issued == NPIX) begin
                fs_req = 1;
                drain_pulsed = 1;
                step();
                fs_req = 0;
                check_eq("busy_in_drain", int'(busy), 1);
            end else begin
                step();
            end
            budget++;
        end
        check_eq("frame_done_seen", fd_cnt, 1);
        step();
        check_eq("frame_done_pulse", int'(frame_done), 0);
        repeat (20) step();
        check_eq("frame_done_once", fd_cnt, 1);
        check_eq("idle_after_frame", int'(busy), 0);
        check_eq("frame_issued", issued, NPIX);
        check_eq("frame_written", writes, NPIX);
    endtask

    initial begin
        int budget;
        rst = 1; frame_start = 0; jw_ready = '0; jw_done = '0; mc_wr_ack = 0;
        en = '0; sticky = 0; spur = 0; fs_req = 0; rst_req = 0;
        ack_dly = 1; cyc = 0; overlap = 0;
        lat = '{3, 3, 3, 3};

        // Reset state, then acks with no grant held must be ignored.
        reset_dut();
        spur = 1;
        repeat (3) step();
        spur = 0;
        step();
        check_idle();

        // Two workers with fixed latency walk the whole frame.
        en = 4'b0011;
        run_frame(0);

        // All four ready and held ready: starts go 0,1,2,3 back to back.
        reset_dut();
        en = 4'b1111; sticky = 1;
        run_frame(0);
        for (int k = 0; k < 4; k++) begin
            check_eq("t2_start_order", iss_w[k], k);
            check_eq("t2_consecutive", iss_c[k] - iss_c[0], k);
        end
        sticky = 0;

        // Workers 1 and 3 finish together; worker 1 wins the first write.
        reset_dut();
        en = 4'b1010; lat = '{3, 4, 3, 3}; ack_dly = 2;
        run_frame(0);
        check_eq("t3_write_count", wr_log.size(), NPIX);
        check_eq("t3_first_grant", wr_log[0], 1);
        check_eq("t3_second_grant", wr_log[1], 3);

        // Mixed latencies so issues and acks of different workers overlap.
        reset_dut();
        en = 4'b1111; lat = '{2, 6, 3, 5}; ack_dly = 0;
        run_frame(0);

        // Reset with three jobs in flight, then a clean frame from (0,0).
        reset_dut();
        en = 4'b1111; lat = '{20, 20, 20, 20}; ack_dly = 0;
        fs_req = 1;
        step();
        fs_req = 0;
        budget = 0;
        while (issued < 3 && budget < 50) begin
            step();
            budget++;
        end
        check_eq("t5_inflight", issued, 3);
        rst_req = 1;
        step();
        @(posedge clk);
        #1;
        check_idle();
        model_reset();
        rst_req = 0;
        step();
        lat = '{3, 3, 3, 3};
        run_frame(0);

        // frame_start during DRAIN is ignored.
        reset_dut();
        en = 4'b0011; ack_dly = 1;
        run_frame(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
